manchester_deframer: RTL and testbench

MANCHESTER_DEFRAMER -- requirements
Module: manchester_deframer

---
 rtl/manchester_deframer_if.sv | 28 ++
 rtl/manchester_deframer.sv | 148 ++++++++++++++
 tb/tb_manchester_deframer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/manchester_deframer_if.sv
// Bit-stream input, AXI-Stream byte output and status pulses of the Manchester deframer.
// slave = deframer side, master = line source / byte sink side.
interface manchester_deframer_if;
    logic       s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       frame_active;
    logic       sync_err;
    logic       overflow_err;
    logic       trunc_err;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output frame_active, sync_err, overflow_err, trunc_err
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  frame_active, sync_err, overflow_err, trunc_err
    );
endinterface

// File: rtl/manchester_deframer.sv
// Preamble hunt, D5 SFD match and MSB-first byte packing with a one-byte holdback; a byte is shown 1 cycle after its successor completes.
// The line is never stalled: if the output is still occupied when a byte must move, the newest byte is dropped and overflow_err pulses.
module manchester_deframer #(
    parameter int MIN_PREAMBLE_BITS = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    manchester_deframer_if.slave bus
);
    typedef enum logic [1:0] {HUNT, SFD, DATA, FLUSH} state_t;

    localparam logic [5:0] MinRun = 6'(MIN_PREAMBLE_BITS);

    state_t     r_state;
    logic [7:0] r_sh;
    logic [7:0] r_pend;
    logic [7:0] r_out_dat;
    logic [5:0] r_run;
    logic [2:0] r_sfd_cnt;
    logic [2:0] r_bit_cnt;
    logic       r_pend_vld;
    logic       r_out_vld;
    logic       r_out_last;
    logic       r_tready;
    logic       r_sync_err;
    logic       r_ovf_err;
    logic       r_trunc_err;

    logic       w_take;
    logic       w_bit;
    logic       w_last;
    logic       w_out_free;
    logic       w_byte_done;
    logic [7:0] w_sh_nxt;

    assign w_take      = bus.s_axis_tvalid;
    assign w_bit       = bus.s_axis_tdata;
    assign w_last      = bus.s_axis_tlast;
    assign w_sh_nxt    = {r_sh[6:0], w_bit};
    assign w_out_free  = !r_out_vld || bus.m_axis_tready;
    assign w_byte_done = (r_bit_cnt == 3'd7);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= HUNT;
            r_sh        <= 8'h00;
            r_pend      <= 8'h00;
            r_out_dat   <= 8'h00;
            r_run       <= 6'd0;
            r_sfd_cnt   <= 3'd0;
            r_bit_cnt   <= 3'd0;
            r_pend_vld  <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_tready    <= 1'b0;
            r_sync_err  <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_trunc_err <= 1'b0;
        end else begin
            r_tready    <= 1'b1;
            r_sync_err  <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_trunc_err <= 1'b0;
            if (r_out_vld && bus.m_axis_tready) r_out_vld <= 1'b0;
            if (w_take) r_sh <= w_sh_nxt;

            case (r_state)
                HUNT: begin
                    if (w_take) begin
                        if (w_last)                r_run <= 6'd0;
                        else if (w_bit != r_sh[0]) r_run <= (r_run == 6'd63) ? r_run : r_run + 6'd1;
                        else if (r_run >= MinRun) begin
                            r_state   <= SFD;
                            r_sfd_cnt <= 3'd6;
                        end else                   r_run <= 6'd1;
                    end
                end
                SFD: begin
                    if (w_take) begin
                        if (w_last) begin
                            r_state   <= HUNT;
                            r_run     <= 6'd0;
                            r_sfd_cnt <= 3'd0;
                        end else if (r_sfd_cnt == 3'd1) begin
                            r_sfd_cnt <= 3'd0;
                            if (w_sh_nxt == 8'hD5) begin
                                r_state   <= DATA;
                                r_bit_cnt <= 3'd0;
                            end else begin
                                r_sync_err <= 1'b1;
                                r_state    <= HUNT;
                                r_run      <= 6'd0;
                            end
                        end else r_sfd_cnt <= r_sfd_cnt - 3'd1;
                    end
                end
                DATA: begin
                    if (w_take) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        // Holdback: the pending byte only leaves once a successor (or tlast) proves it exists.
                        if (w_byte_done) begin
                            if (!r_pend_vld) begin
                                r_pend     <= w_sh_nxt;
                                r_pend_vld <= 1'b1;
                            end else if (w_out_free) begin
                                r_out_dat  <= r_pend;
                                r_out_last <= 1'b0;
                                r_out_vld  <= 1'b1;
                                r_pend     <= w_sh_nxt;
                            end else r_ovf_err <= 1'b1;
                        end
                        if (w_last) begin
                            if (!w_byte_done) r_trunc_err <= 1'b1;
                            if (w_byte_done || r_pend_vld) r_state <= FLUSH;
                            else begin
                                r_state   <= HUNT;
                                r_run     <= 6'd0;
                                r_bit_cnt <= 3'd0;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (w_out_free) begin
                        r_out_dat  <= r_pend;
                        r_out_last <= 1'b1;
                        r_out_vld  <= 1'b1;
                        r_pend_vld <= 1'b0;
                        r_state    <= HUNT;
                        r_run      <= 6'd0;
                        r_sfd_cnt  <= 3'd0;
                        r_bit_cnt  <= 3'd0;
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    assign bus.s_axis_tready = r_tready;
    assign bus.m_axis_tdata  = r_out_dat;
    assign bus.m_axis_tvalid = r_out_vld;
    assign bus.m_axis_tlast  = r_out_last;
    assign bus.frame_active  = (r_state != HUNT);
    assign bus.sync_err      = r_sync_err;
    assign bus.overflow_err  = r_ovf_err;
    assign bus.trunc_err     = r_trunc_err;
endmodule

// File: tb/tb_manchester_deframer.sv
// Directed frames plus randomized bursts checked against a frame-level parse of the bit stream.
module tb_manchester_deframer;
    localparam int MIN = 16;

    logic aclk = 1'b0;
    logic areset;
    manchester_deframer_if bus();

    manchester_deframer #(.MIN_PREAMBLE_BITS(MIN)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         burst[$];
    logic [7:0] exp_dat[$];
    int         exp_sync, exp_trunc, exp_ovf;
    logic [7:0] got_dat[$];
    bit         got_last[$];
    int         got_sync, got_trunc, got_ovf;
    int         rdy_mode = 1;
    int         stall = 0;
    logic       h_vld = 1'b0;
    logic [8:0] h_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) burst.push_back(b[i]);
    endtask

    task automatic send_bits(input int gap_max, input bit with_last);
        for (int i = 0; i < burst.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) cyc();
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = burst[i];
            bus.s_axis_tlast  = with_last && (i == burst.size() - 1);
            cyc();
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tlast  = 1'b0;
        end
        burst.delete();
    endtask

    task automatic clear_obs();
        got_dat.delete();
        got_last.delete();
        got_sync = 0; got_trunc = 0; got_ovf = 0;
    endtask

    task automatic check_frame(input string tag);
        chk($sformatf("%s_count", tag), got_dat.size(), exp_dat.size());
        for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got_dat[i], exp_dat[i]);
            chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == exp_dat.size() - 1));
        end
        chk({tag, "_sync"}, got_sync, exp_sync);
        chk({tag, "_trunc"}, got_trunc, exp_trunc);
        chk({tag, "_ovf"}, got_ovf, exp_ovf);
    endtask

    // Parse one tlast-terminated burst: find a repeated bit ending an alternating streak of >= MIN,
    // test the 8-bit window ending six bits later for D5, then slice the rest into bytes.
    task automatic model_burst();
        int n, s, st, p, len;
        logic [7:0] w;
        n = burst.size(); s = 0;
        exp_dat.delete(); exp_sync = 0; exp_trunc = 0; exp_ovf = 0;
        while (s < n) begin
            p = -1; st = s;
            for (int i = s + 1; i < n; i++) begin
                if (burst[i] == burst[i-1]) begin
                    if (i - st >= MIN) begin p = i; break; end
                    st = i;
                end
            end
            if (p < 0 || p + 6 >= n - 1) return;
            w = 8'h00;
            for (int k = 0; k < 8; k++) w = {w[6:0], burst[p-1+k]};
            if (w != 8'hD5) begin
                exp_sync++;
                s = p + 7;
                continue;
            end
            len = n - (p + 7);
            for (int j = 0; j < len / 8; j++) begin
                w = 8'h00;
                for (int k = 0; k < 8; k++) w = {w[6:0], burst[p+7+8*j+k]};
                exp_dat.push_back(w);
            end
            if (len % 8 != 0) exp_trunc++;
            return;
        end
    endtask

    initial begin
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (rdy_mode == 0)      bus.m_axis_tready = 1'b0;
            else if (rdy_mode == 1) bus.m_axis_tready = 1'b1;
            else if (stall > 0) begin
                bus.m_axis_tready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.m_axis_tready = 1'b0;
                stall = $urandom_range(0, 2);
            end else bus.m_axis_tready = 1'b1;
        end
    end

    always @(negedge aclk) begin
        if (areset) h_vld = 1'b0;
        else begin
            if (h_vld) begin
                chk("hold_vld", bus.m_axis_tvalid, 1);
                chk("hold_word", {bus.m_axis_tlast, bus.m_axis_tdata}, h_word);
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                got_dat.push_back(bus.m_axis_tdata);
                got_last.push_back(bus.m_axis_tlast);
            end
            got_sync  += int'(bus.sync_err);
            got_trunc += int'(bus.trunc_err);
            got_ovf   += int'(bus.overflow_err);
            h_vld  = bus.m_axis_tvalid && !bus.m_axis_tready;
            h_word = {bus.m_axis_tlast, bus.m_axis_tdata};
        end
    end

    initial begin
        int base, plen, npay;
        areset = 1'b1;
        bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = 1'b0; bus.s_axis_tlast = 1'b0;
        clear_obs();
        idle(3);
        chk("rst_tready", bus.s_axis_tready, 0);
        chk("rst_word", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}, 0);
        chk("rst_status", {bus.frame_active, bus.sync_err, bus.overflow_err, bus.trunc_err}, 0);
        areset = 1'b0;
        cyc();
        chk("tready_after_rst", bus.s_axis_tready, 1);

        // Basic three-byte frame
        clear_obs();
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5);
        add_byte(8'h11); add_byte(8'h22); add_byte(8'h33);
        send_bits(0, 1); idle(6);
        exp_dat = '{8'h11, 8'h22, 8'h33}; exp_sync = 0; exp_trunc = 0; exp_ovf = 0;
        check_frame("basic");

        // 12-bit preamble is too short
        clear_obs();
        for (int i = 0; i < 12; i++) burst.push_back(bit'((i + 1) % 2));
        add_byte(8'hD5); add_byte(8'h00);
        send_bits(0, 1); idle(6);
        exp_dat.delete();
        check_frame("short_pre");

        // Bad SFD, then a good frame is re-acquired
        clear_obs();
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hC5); add_byte(8'h44);
        send_bits(0, 1); idle(4);
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5); add_byte(8'h5A);
        send_bits(1, 1); idle(6);
        exp_dat = '{8'h5A}; exp_sync = 1;
        check_frame("bad_sfd");

        // Truncated tail
        clear_obs();
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5); add_byte(8'h11); add_byte(8'h22);
        burst.push_back(1'b1); burst.push_back(1'b0); burst.push_back(1'b1);
        send_bits(0, 1); idle(6);
        exp_dat = '{8'h11, 8'h22}; exp_sync = 0; exp_trunc = 1;
        check_frame("trunc");

        // Sink stalled for the whole frame
        rdy_mode = 0; idle(2);
        clear_obs();
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5);
        add_byte(8'h01); add_byte(8'h02); add_byte(8'h03); add_byte(8'h04);
        send_bits(0, 1); idle(5);
        chk("stall_ovf", got_ovf, 2);
        chk("stall_word", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}, {2'b10, 8'h01});
        rdy_mode = 1; idle(8);
        exp_dat = '{8'h01, 8'h02}; exp_trunc = 0; exp_ovf = 2;
        check_frame("stall");

        // Reset in the middle of the payload
        clear_obs();
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5);
        for (int i = 0; i < 4; i++) burst.push_back(1'b1);
        send_bits(0, 0); idle(1);
        chk("mid_active", bus.frame_active, 1);
        areset = 1'b1; idle(2);
        chk("mid_rst_word", {bus.m_axis_tvalid, bus.frame_active, bus.sync_err, bus.overflow_err, bus.trunc_err}, 0);
        areset = 1'b0; idle(2);
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5); add_byte(8'h77);
        send_bits(0, 1); idle(6);
        exp_dat = '{8'h77}; exp_ovf = 0;
        check_frame("mid_rst");

        // Randomized bursts with a briefly stalling sink
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            clear_obs();
            repeat ($urandom_range(0, 6)) burst.push_back(bit'($urandom_range(0, 1)));
            plen = $urandom_range(MIN - 2, MIN + 10);
            for (int j = 0; j < plen; j++) burst.push_back(bit'((plen - 1 - j) % 2));
            base = burst.size();
            add_byte(8'hD5);
            if ($urandom_range(0, 4) == 0) burst[base + $urandom_range(0, 7)] ^= 1'b1;
            npay = $urandom_range(0, 40);
            repeat (npay) burst.push_back(bit'($urandom_range(0, 1)));
            model_burst();
            send_bits(2, 1);
            idle(12);
            check_frame($sformatf("rnd%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
